// File: rtl/div_unit.sv
// Signed restoring divider: quotient to lo, remainder to hi, MIPS truncation semantics.
// Latency: WIDTH+2 edges from the start edge to done. A start is taken only in IDLE or DONE.
// There is no backpressure: a start that arrives while busy is dropped.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    count_q, count_d;
    logic             sign_q_q, sign_q_d;
    logic             sign_r_q, sign_r_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             div_zero_q, div_zero_d;

    logic [WIDTH:0]   shifted;
    logic             ge;

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        count_d    = count_q;
        sign_q_d   = sign_q_q;
        sign_r_d   = sign_r_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        div_zero_d = 1'b0;

        // Next dividend bit enters the partial remainder from the top of quo.
        shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        ge      = (shifted >= {1'b0, dvs_q});

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                if (start) begin
                    if (b == '0) begin
                        div_zero_d = 1'b1;
                    end else begin
                        sign_q_d = a[WIDTH-1] ^ b[WIDTH-1];
                        sign_r_d = a[WIDTH-1];
                        quo_d    = a[WIDTH-1] ? -a : a;
                        dvs_d    = b[WIDTH-1] ? -b : b;
                        rem_d    = '0;
                        count_d  = '0;
                        busy_d   = 1'b1;
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                rem_d   = ge ? (shifted - {1'b0, dvs_q}) : shifted;
                quo_d   = {quo_q[WIDTH-2:0], ge};
                count_d = count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                lo_d    = sign_q_q ? -quo_q : quo_q;
                hi_d    = sign_r_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            count_q    <= '0;
            sign_q_q   <= 1'b0;
            sign_r_q   <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
            count_q    <= count_d;
            sign_q_q   <= sign_q_d;
            sign_r_q   <= sign_r_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: reset, signed results, overflow, divide-by-zero, ignored start, reset abort.
module tb_div_unit;
    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    int checks = 0;
    int errors = 0;

    div_unit #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .start(start), .a(a), .b(b),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Pulses start for one edge (E0), then waits for done. lat counts edges
    // from E0 inclusive up to the edge that raised done; busy_cnt counts
    // sampled cycles with busy high. A missing done leaves lat at 100.
    task automatic run_div(input logic [31:0] av, input logic [31:0] bv,
                           output int lat, output int busy_cnt);
        @(negedge clock);
        a = av; b = bv; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        a = 32'hDEAD_BEEF; b = 32'h1234_5678;
        lat = 1; busy_cnt = 0;
        while (!done && lat < 100) begin
            busy_cnt += int'(busy);
            @(posedge clock); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; start = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clock);
        @(negedge clock); reset = 1'b1;
        @(posedge clock); #1;
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 00000000", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 00000000", lo); end
        checks++; if ({busy, done, div_zero} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {busy, done, div_zero}); end
    endtask

    task automatic test_basic;
        int lat, bc;
        run_div(32'd100, 32'd7, lat, bc);
        checks++; if (lat !== 34) begin errors++; $display("FAIL basic_latency: got %0d want 34", lat); end
        checks++; if (bc !== 33) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 33", bc); end
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL basic_lo: got %h want 0000000e", lo); end
        checks++; if (hi !== 32'd2) begin errors++; $display("FAIL basic_hi: got %h want 00000002", hi); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %b want 0", busy); end
        @(posedge clock); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_one_cycle: got %b want 0", done); end
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL basic_lo_hold: got %h want 0000000e", lo); end
    endtask

    task automatic test_signs;
        int lat, bc;
        run_div(32'hFFFF_FFF9, 32'd2, lat, bc);
        checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL neg_dividend_lo: got %h want fffffffd", lo); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL neg_dividend_hi: got %h want ffffffff", hi); end
        run_div(32'd7, 32'hFFFF_FFFE, lat, bc);
        checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL neg_divisor_lo: got %h want fffffffd", lo); end
        checks++; if (hi !== 32'd1) begin errors++; $display("FAIL neg_divisor_hi: got %h want 00000001", hi); end
        run_div(32'hFFFF_FF9C, 32'hFFFF_FFF9, lat, bc);
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL both_neg_lo: got %h want 0000000e", lo); end
        checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL both_neg_hi: got %h want fffffffe", hi); end
    endtask

    task automatic test_overflow_divzero;
        int lat, bc;
        run_div(32'h8000_0000, 32'hFFFF_FFFF, lat, bc);
        checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL overflow_lo: got %h want 80000000", lo); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL overflow_hi: got %h want 00000000", hi); end
        // Start lands in the DONE cycle, which must be accepted like IDLE.
        a = 32'd5; b = 32'd0; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        checks++; if ({div_zero, done, busy} !== 3'b100) begin errors++; $display("FAIL divzero_pulse: got dz/done/busy=%b want 100", {div_zero, done, busy}); end
        @(posedge clock); #1;
        checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL divzero_one_cycle: got %b want 0", div_zero); end
        repeat (5) begin
            @(posedge clock); #1;
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL divzero_no_done: got %b want 0", done); end
        end
        checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL divzero_lo_kept: got %h want 80000000", lo); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL divzero_hi_kept: got %h want 00000000", hi); end
    endtask

    task automatic test_ignore_start;
        int lat;
        @(negedge clock);
        a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin
            if (lat == 10) begin
                a = 32'd1; b = 32'd1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clock); #1;
            lat++;
        end
        start = 1'b0;
        checks++; if (lat !== 34) begin errors++; $display("FAIL ignore_latency: got %0d want 34", lat); end
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL ignore_lo: got %h want 0000000e", lo); end
        checks++; if (hi !== 32'd2) begin errors++; $display("FAIL ignore_hi: got %h want 00000002", hi); end
        repeat (2) @(posedge clock);
    endtask

    task automatic test_reset_abort;
        int lat, bc, seen;
        // Leaves 14/2 in hi/lo so the abort clearing them is visible.
        @(negedge clock);
        a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (14) @(posedge clock);
        @(negedge clock); reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL abort_hi: got %h want 00000000", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL abort_lo: got %h want 00000000", lo); end
        seen = 0;
        repeat (40) begin
            @(posedge clock); #1;
            seen += int'(done);
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_done: got %0d done pulses want 0", seen); end
        run_div(32'd9, 32'd3, lat, bc);
        checks++; if (lat !== 34) begin errors++; $display("FAIL post_reset_latency: got %0d want 34", lat); end
        checks++; if (lo !== 32'd3) begin errors++; $display("FAIL post_reset_lo: got %h want 00000003", lo); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL post_reset_hi: got %h want 00000000", hi); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_overflow_divzero();
        test_ignore_start();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle signed 32-bit divider: operand A is the dividend and operand B is the divisor.
- Its quotient feeds the LO register and its remainder feeds the HI register, through the div/mult select muxes of the multicycle MIPS datapath.
- Started by a one-cycle pulse from the control unit.
- Reports completion and divide-by-zero back to the control unit, which raises the exception.

Parameters:
- WIDTH, 32, operand/result width in bits; iteration count equals WIDTH.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request; operands sampled on the same edge.
- a  in  WIDTH  dividend (two's complement).
- b  in  WIDTH  divisor (two's complement).
- hi  out  WIDTH  remainder, registered.
- lo  out  WIDTH  quotient, registered.
- busy  out  1  high while a division is in progress.
- done  out  1  one-cycle pulse when hi/lo carry a new result.
- div_zero  out  1  one-cycle pulse when start was issued with b==0.

Behaviour:
- Reset: sampled on the rising edge while reset==0. State goes to IDLE. hi, lo and the internal remainder/quotient/divisor/count/sign registers clear to 0. busy, done and div_zero are 0. Reset overrides start and aborts any division in progress; no done is produced for it.
- Sign capture: on accepted start, store sign_q = a[W-1]^b[W-1] and sign_r = a[W-1]. Store |a| and |b| as unsigned W-bit magnitudes; |0x80000000| = 0x80000000 unsigned. Clear the partial remainder (W+1 bits) and set count = 0.
- Algorithm: restoring, one quotient bit per cycle, MSB first.
  - Shift {rem, quo} left 1, bringing in the next dividend bit.
  - If rem >= divisor, subtract the divisor and set the quotient LSB to 1.
- IDLE:
  - busy=0.
  - If start and b!=0: capture operands, go to CALC.
  - If start and b==0: div_zero=1 in the following cycle, stay IDLE, hi/lo unchanged.
- CALC:
  - busy=1; one iteration per cycle, count increments.
  - After the WIDTH-th iteration (count==WIDTH-1 on that edge), go to FIX.
- FIX:
  - busy=1.
  - lo <= sign_q ? -quo : quo.
  - hi <= sign_r ? -rem[W-1:0] : rem[W-1:0].
  - Go to DONE.
- DONE:
  - done=1, busy=0 for exactly one cycle, then IDLE.
  - A start in DONE is accepted as if in IDLE.
- Latency: start sampled at edge E0. CALC occupies edges E1..EW. FIX at EW+1. hi/lo valid and done=1 during the cycle after edge EW+1 (W+2 edges; 34 for W=32).
- start while in CALC or FIX: ignored; operands are not resampled.
- a/b may change after the start edge without affecting the result.
- Semantics are MIPS truncation:
  - The quotient rounds toward zero.
  - The remainder takes the sign of the dividend.
  - |rem| < |b|.
- Overflow case 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0. No flag is raised.
- hi/lo hold their last values until the next FIX or reset. The datapath may read them any time after done.
- done and div_zero are never high in the same cycle.

Test Plan:
- Reset low 2 cycles, then high -> hi=0, lo=0, busy=0, done=0, div_zero=0.
- a=100, b=7, start pulse -> busy for 33 cycles; done pulse 34 edges after start; lo=14, hi=2.
- a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Then a=7, b=-2 -> lo=0xFFFFFFFD, hi=1.
- a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. Then a=5, b=0 -> div_zero pulse the next cycle, no done, hi/lo keep 0x00000000/0x80000000.
- Start a=100, b=7; pulse start again with a=1, b=1 at cycle 10 -> second start ignored; result lo=14, hi=2.
- Start a=100, b=7; drive reset low at cycle 15 -> next edge busy=0, hi=lo=0, no done. New start a=9, b=3 after reset -> lo=3, hi=0.
